inst_queue: RTL and testbench
=============================

INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 Parameter DEPTH, default core_pkg::IQ_DEPTH (8), queue entries; power of 2, >= 2*FETCH_WIDTH.
REQ-002 Parameter FETCH_W, default core_pkg::FETCH_WIDTH (2), enqueue/dequeue slots per cycle.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  redirect/flush; discards all queue contents.
REQ-006 enq_valid  input  FETCH_W  per-slot valid from fetch (if_valid); slot 0 older.
REQ-007 enq_pc  input  XLEN x FETCH_W  per-slot PC (if_pc).
REQ-008 enq_instr  input  XLEN x FETCH_W  per-slot instruction (if_instr).
REQ-009 fetch_stall  output  1  backpressure to fetch stall input.
REQ-010 deq_valid  output  FETCH_W  per-slot valid to decode.
REQ-011 deq_pc  output  XLEN x FETCH_W  oldest-first PCs.
REQ-012 deq_instr  output  XLEN x FETCH_W  oldest-first instructions.
REQ-013 dec_ready  input  1  decode consumes every asserted deq_valid slot this cycle.
REQ-014 overflow_err  output  1  sticky error flag.

Function
REQ-015 Circular buffer with head, tail and count; pointers SHALL wrap modulo DEPTH; count width clog2(DEPTH)+1.
REQ-016 Enqueue SHALL compact valid slots in order: pattern 11 writes slot0 at tail and slot1 at tail+1; 01 or 10 writes the single valid slot at tail.
REQ-017 Enqueue SHALL be accepted only if pre-dequeue free space >= popcount(enq_valid); same-cycle dequeue space SHALL NOT be reused.
REQ-018 A rejected enqueue SHALL drop all slots of that cycle and set overflow_err, which holds until reset.
REQ-019 fetch_stall SHALL be combinational and equal 1 when free < 2*FETCH_W; this reserves skid room for the 1-cycle imem response in flight.
REQ-020 deq slot i SHALL present entry head+i from registered storage; deq_valid[i] = (count > i) and !flush.
REQ-021 When dec_ready=1, head SHALL advance by popcount(deq_valid) and those entries are consumed.
REQ-022 Latency: an entry enqueued at edge N SHALL appear on deq after edge N; there is no combinational enq-to-deq bypass.
REQ-023 With simultaneous enqueue and dequeue, count_next = count + n_enq - n_deq, and program order SHALL be preserved.
REQ-024 flush SHALL have highest priority: head, tail and count become 0 at the edge; same-cycle enqueue and dequeue are ignored.
REQ-025 Empty queue: deq_valid=00, and dec_ready has no effect.

Reset
REQ-026 On reset=1 at a clock edge: head, tail and count = 0; overflow_err=0; hence deq_valid=0 and fetch_stall=0.
REQ-027 Storage arrays SHALL NOT be reset; deq_pc and deq_instr contents are don't-care while deq_valid=0.
REQ-028 Reset SHALL override flush and enqueue in the same cycle; reset asserted mid-operation empties the queue at the next edge.

Structure
REQ-029 core_pkg SHALL hold XLEN, FETCH_WIDTH, the new IQ_DEPTH constant and the typedef iq_entry_t {pc, instr}.
REQ-030 The block SHALL be a single module with no sub-module; popcount and pointer-add helpers are local functions.

Verification
REQ-031 After reset, enq_valid=11, pc 0x00/0x04, instr 0x11111111/0x22222222, dec_ready=0 -> next cycle deq_valid=11 with deq_pc 0x00/0x04; count=2.
REQ-032 DEPTH=8, dec_ready=0, enq 11 for three cycles -> count=6 and fetch_stall=1; after one dequeue of 2, fetch_stall=0.
REQ-033 Empty queue, enq_valid=10 with slot1 pc=0x14, instr=0x66666666 -> deq_valid=01, deq_pc[0]=0x14.
REQ-034 count=3, enq 11 together with dec_ready=1 -> count=3; new deq slot0 is the former third entry; order intact.
REQ-035 count=5, flush=1 with enq 11 in the same cycle -> next cycle count=0, deq_valid=00, fetch_stall=0; that enqueue is lost.
REQ-036 count=7, enq 11, dec_ready=0 -> both slots dropped; overflow_err=1 stays set until reset; count stays 7.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core-wide constants and the instruction-queue entry type.
// The instruction queue sits between the fetch and decode stages.
package core_pkg;

    localparam int XLEN        = 32;
    localparam int FETCH_WIDTH = 2;
    localparam int IQ_DEPTH    = 8;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } iq_entry_t;

endpackage

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode.
// It is a multi-slot circular buffer with in-order compaction, sticky overflow and fetch backpressure.
module inst_queue
    import core_pkg::*;
#(
    parameter int DEPTH   = core_pkg::IQ_DEPTH,
    parameter int FETCH_W = core_pkg::FETCH_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic [FETCH_W-1:0]            enq_valid,
    input  logic [FETCH_W-1:0][XLEN-1:0]  enq_pc,
    input  logic [FETCH_W-1:0][XLEN-1:0]  enq_instr,
    output logic                          fetch_stall,
    output logic [FETCH_W-1:0]            deq_valid,
    output logic [FETCH_W-1:0][XLEN-1:0]  deq_pc,
    output logic [FETCH_W-1:0][XLEN-1:0]  deq_instr,
    input  logic                          dec_ready,
    output logic                          overflow_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    function automatic logic [CNT_W-1:0] popcount(input logic [FETCH_W-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    // Pointers are exactly log2(DEPTH) bits wide, so the addition wraps modulo DEPTH for free.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input logic [PTR_W-1:0] off);
        return p + off;
    endfunction

    iq_entry_t              mem_q [DEPTH];
    logic [PTR_W-1:0]       head_q, head_d;
    logic [PTR_W-1:0]       tail_q, tail_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   overflow_q, overflow_d;

    logic [CNT_W-1:0]       free_cnt;
    logic [CNT_W-1:0]       n_enq;
    logic [CNT_W-1:0]       n_deq;
    logic                   enq_ok;
    logic [PTR_W-1:0]       slot_off;
    logic [FETCH_W-1:0]     wr_en;
    logic [PTR_W-1:0]       wr_idx  [FETCH_W];
    iq_entry_t              wr_data [FETCH_W];

    always_comb begin
        free_cnt    = CNT_W'(DEPTH) - count_q;
        fetch_stall = free_cnt < CNT_W'(2 * FETCH_W);
        for (int i = 0; i < FETCH_W; i++) begin
            deq_valid[i] = (count_q > CNT_W'(i)) && !flush;
            deq_pc[i]    = mem_q[ptr_add(head_q, PTR_W'(i))].pc;
            deq_instr[i] = mem_q[ptr_add(head_q, PTR_W'(i))].instr;
        end
        overflow_err = overflow_q;
    end

    // Free space is judged before this cycle's dequeue, so a full queue never reuses a slot being drained.
    always_comb begin
        n_enq  = popcount(enq_valid);
        n_deq  = dec_ready ? popcount(deq_valid) : '0;
        enq_ok = n_enq <= free_cnt;

        slot_off = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            wr_en[i]   = enq_valid[i] && enq_ok && !flush;
            wr_idx[i]  = ptr_add(tail_q, slot_off);
            wr_data[i] = '{pc: enq_pc[i], instr: enq_instr[i]};
            slot_off   = slot_off + PTR_W'(enq_valid[i]);
        end

        head_d     = ptr_add(head_q, PTR_W'(n_deq));
        tail_d     = enq_ok ? ptr_add(tail_q, PTR_W'(n_enq)) : tail_q;
        count_d    = count_q + (enq_ok ? n_enq : '0) - n_deq;
        overflow_d = overflow_q || !enq_ok;

        if (flush) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_W; i++) begin
            if (wr_en[i]) begin
                mem_q[wr_idx[i]] <= wr_data[i];
            end
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Randomized self-checking bench for inst_queue.
// The reference model is a plain queue of {pc, instr} entries.
module tb_inst_queue;
    import core_pkg::*;

    localparam int DEPTH = IQ_DEPTH;
    localparam int FW    = FETCH_WIDTH;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   flush;
    logic [FW-1:0]          enq_valid;
    logic [FW-1:0][XLEN-1:0] enq_pc;
    logic [FW-1:0][XLEN-1:0] enq_instr;
    logic                   fetch_stall;
    logic [FW-1:0]          deq_valid;
    logic [FW-1:0][XLEN-1:0] deq_pc;
    logic [FW-1:0][XLEN-1:0] deq_instr;
    logic                   dec_ready;
    logic                   overflow_err;

    int checks = 0;
    int errors = 0;

    logic [63:0] model_q[$];
    logic        model_ovf = 1'b0;

    always #5 clk = ~clk;

    inst_queue dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .enq_valid    (enq_valid),
        .enq_pc       (enq_pc),
        .enq_instr    (enq_instr),
        .fetch_stall  (fetch_stall),
        .deq_valid    (deq_valid),
        .deq_pc       (deq_pc),
        .deq_instr    (deq_instr),
        .dec_ready    (dec_ready),
        .overflow_err (overflow_err)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic model_stall();
        return (DEPTH - model_q.size()) < 2 * FW;
    endfunction

    // Drive one cycle at the falling edge, check outputs, then advance the model across the rising edge.
    task automatic applyStimulus(input logic rst, input logic fl, input logic [FW-1:0] ev,
                                 input logic [XLEN-1:0] pc0, input logic [XLEN-1:0] pc1,
                                 input logic [XLEN-1:0] in0, input logic [XLEN-1:0] in1,
                                 input logic rdy);
        logic [FW-1:0] exp_valid;
        int            n_enq;
        int            n_deq;
        reset        = rst;
        flush        = fl;
        enq_valid    = ev;
        enq_pc[0]    = pc0;
        enq_pc[1]    = pc1;
        enq_instr[0] = in0;
        enq_instr[1] = in1;
        dec_ready    = rdy;
        #1;
        for (int i = 0; i < FW; i++) begin
            exp_valid[i] = !fl && (model_q.size() > i);
        end
        checkOutput("deq_valid", 64'(deq_valid), 64'(exp_valid));
        checkOutput("fetch_stall", 64'(fetch_stall), 64'(model_stall()));
        checkOutput("overflow_err", 64'(overflow_err), 64'(model_ovf));
        for (int i = 0; i < FW; i++) begin
            if (exp_valid[i]) begin
                checkOutput($sformatf("deq_slot%0d", i), {deq_pc[i], deq_instr[i]}, model_q[i]);
            end
        end
        @(posedge clk);
        if (rst) begin
            model_q.delete();
            model_ovf = 1'b0;
        end else if (fl) begin
            model_q.delete();
        end else begin
            n_enq = $countones(ev);
            n_deq = rdy ? ((model_q.size() < FW) ? model_q.size() : FW) : 0;
            if (n_enq <= DEPTH - model_q.size()) begin
                for (int i = 0; i < n_deq; i++) void'(model_q.pop_front());
                if (ev[0]) model_q.push_back({pc0, in0});
                if (ev[1]) model_q.push_back({pc1, in1});
            end else begin
                for (int i = 0; i < n_deq; i++) void'(model_q.pop_front());
                model_ovf = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        applyStimulus(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, rdy);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic pushPair(input logic [FW-1:0] ev, input logic [XLEN-1:0] base, input logic rdy);
        applyStimulus(1'b0, 1'b0, ev, base, base + 32'h4, {base[7:0], 24'h111111}, {base[7:0], 24'h222222}, rdy);
    endtask

    initial begin
        logic          r_rst;
        logic          r_fl;
        logic [FW-1:0] r_ev;
        logic          r_rdy;
        reset     = 1'b1;
        flush     = 1'b0;
        enq_valid = '0;
        enq_pc    = '0;
        enq_instr = '0;
        dec_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        doReset();

        // Two-slot enqueue after reset, visible one cycle later.
        applyStimulus(1'b0, 1'b0, 2'b11, 32'h00, 32'h04, 32'h11111111, 32'h22222222, 1'b0);
        idle(1'b0);

        // Fill to six entries, then drain one pair to release the stall.
        doReset();
        pushPair(2'b11, 32'h100, 1'b0);
        pushPair(2'b11, 32'h200, 1'b0);
        pushPair(2'b11, 32'h300, 1'b0);
        idle(1'b1);
        idle(1'b0);

        // Only slot 1 valid lands at the tail.
        doReset();
        applyStimulus(1'b0, 1'b0, 2'b10, 32'h10, 32'h14, 32'h55555555, 32'h66666666, 1'b0);
        idle(1'b0);

        // Three entries, then simultaneous enqueue of two and dequeue of two.
        doReset();
        pushPair(2'b11, 32'h400, 1'b0);
        pushPair(2'b01, 32'h500, 1'b0);
        pushPair(2'b11, 32'h600, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Five entries, then flush with a same-cycle enqueue that must be lost.
        doReset();
        pushPair(2'b11, 32'h700, 1'b0);
        pushPair(2'b11, 32'h800, 1'b0);
        pushPair(2'b01, 32'h900, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'b11, 32'hA00, 32'hA04, 32'h1, 32'h2, 1'b1);
        idle(1'b1);

        // Seven entries, then an enqueue of two overflows and is dropped.
        doReset();
        pushPair(2'b11, 32'hB00, 1'b0);
        pushPair(2'b11, 32'hC00, 1'b0);
        pushPair(2'b11, 32'hD00, 1'b0);
        pushPair(2'b01, 32'hE00, 1'b0);
        pushPair(2'b11, 32'hF00, 1'b0);
        idle(1'b0);
        applyStimulus(1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        idle(1'b0);
        doReset();
        idle(1'b0);

        for (int n = 0; n < 600; n++) begin
            r_rst = ($urandom_range(0, 99) == 0);
            r_fl  = ($urandom_range(0, 19) == 0);
            r_ev  = FW'($urandom_range(0, 3));
            r_rdy = ($urandom_range(0, 2) != 0);
            if (model_stall() && $urandom_range(0, 7) != 0) r_ev = '0;
            applyStimulus(r_rst, r_fl, r_ev, $urandom, $urandom, $urandom, $urandom, r_rdy);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
